seq_scan_ctrl: RTL and testbench

Controller that sequences the serial sequence-detector state machine.
- Accepts parallel words on a valid/ready interface and shifts each word MSB-first onto the detector's serial input (det_x), one bit per clock.
- Samples the detector's Moore output (det_w) and returns a per-word match count and first-match bit index on a second valid/ready interface.
- Can optionally clear the detector before a word so that words are scanned independently.

---
 rtl/seq_scan_pkg.sv | 16 +
 rtl/seq_scan_acc.sv | 54 +++++
 rtl/seq_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_seq_scan_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Shared state encoding and default sizing for the sequence-detector scan controller.
package seq_scan_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;
  localparam int IDX_W_DEF  = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    TAIL   = 3'd3,
    REPORT = 3'd4
  } state_t;

endpackage

// File: rtl/seq_scan_acc.sv
// Samples the detector output one cycle behind the shifted bit and accumulates
// a saturating match count plus the index of the first matching bit.
module seq_scan_acc
  import seq_scan_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             shifting,
  input  logic [IDX_W-1:0] idx,
  input  logic             det_w,
  output logic [CNT_W-1:0] count,
  output logic [IDX_W-1:0] first,
  output logic             hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             samp_en;
  logic [IDX_W-1:0] samp_idx;
  logic             found;

  // det_w reflects the bit presented in the previous cycle, so the enable and
  // index are delayed by one to line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_en  <= 1'b0;
      samp_idx <= '0;
      count    <= '0;
      first    <= '0;
      found    <= 1'b0;
    end else begin
      samp_en  <= shifting;
      samp_idx <= idx;
      if (start) begin
        count <= '0;
        first <= '0;
        found <= 1'b0;
      end else if (samp_en && det_w) begin
        if (count != CNT_MAX) count <= count + 1'b1;
        if (!found) begin
          first <= samp_idx;
          found <= 1'b1;
        end
      end
    end
  end

  assign hit = (count != '0);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Feeds parallel words MSB-first into a serial sequence detector and reports
// the per-word match count and first-match index.
//
// state  | meaning
// IDLE   | waiting for a word, in_ready high
// CLEAR  | one-cycle det_clr pulse before shifting
// SHIFT  | one word bit per cycle on det_x
// TAIL   | det_x low, last bit's detector response is sampled
// REPORT | result held until res_ready
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_clr_det,
  output logic              det_x,
  output logic              det_clr,
  input  logic              det_w,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic [IDX_W-1:0]  res_first,
  output logic              res_hit,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic              start;
  logic              shifting;

  assign start    = in_valid && in_ready;
  assign shifting = (state == SHIFT);

  // det_x is registered, so each transition into or within SHIFT loads the
  // next bit and the shift register keeps only the bits still to be sent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      det_x     <= 1'b0;
      det_clr   <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      det_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_clr_det) begin
              state   <= CLEAR;
              det_clr <= 1'b1;
              shreg   <= in_data;
            end else begin
              state <= SHIFT;
              det_x <= in_data[WORD_W-1];
              shreg <= {in_data[WORD_W-2:0], 1'b0};
            end
          end
        end
        CLEAR: begin
          state <= SHIFT;
          det_x <= shreg[WORD_W-1];
          shreg <= {shreg[WORD_W-2:0], 1'b0};
        end
        SHIFT: begin
          if (idx == LAST_IDX) begin
            state <= TAIL;
            det_x <= 1'b0;
          end else begin
            idx   <= idx + 1'b1;
            det_x <= shreg[WORD_W-1];
            shreg <= {shreg[WORD_W-2:0], 1'b0};
          end
        end
        TAIL: begin
          state     <= REPORT;
          res_valid <= 1'b1;
        end
        REPORT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          det_x     <= 1'b0;
          res_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  seq_scan_acc #(
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .shifting (shifting),
    .idx      (idx),
    .det_w    (det_w),
    .count    (res_count),
    .first    (res_first),
    .hit      (res_hit)
  );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl with a Moore "1101" overlapping detector model and a
// bit-stream reference model for per-word match results.
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_clr_det = 1'b0;
  logic       det_x;
  logic       det_clr;
  logic       det_w;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_count;
  logic [2:0] res_first;
  logic       res_hit;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [2:0] prev_bits = 3'b000;

  seq_scan_ctrl #(.WORD_W(8), .CNT_W(4), .IDX_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_clr_det (in_clr_det),
    .det_x      (det_x),
    .det_clr    (det_clr),
    .det_w      (det_w),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count  (res_count),
    .res_first  (res_first),
    .res_hit    (res_hit),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Detector: last four bits seen; w is high the cycle after "1101" completes.
  logic [3:0] hist;
  always @(posedge clk or negedge reset) begin
    if (!reset) hist <= 4'b0000;
    else if (det_clr) hist <= 4'b0000;
    else hist <= {hist[2:0], det_x};
  end
  assign det_w = (hist == 4'b1101);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stream seen by the detector: previous word's tail (or nothing after a
  // clear), at least two idle zeros, then the word MSB-first.
  function automatic void model(input logic [7:0] d, input logic c, input logic [2:0] prev,
                                output int cnt, output int first);
    logic b [13];
    cnt = 0;
    first = 0;
    for (int k = 0; k < 3; k++) b[k] = c ? 1'b0 : prev[2-k];
    b[3] = 1'b0;
    b[4] = 1'b0;
    for (int i = 0; i < 8; i++) b[5+i] = d[7-i];
    for (int i = 0; i < 8; i++) begin
      int p;
      p = 5 + i;
      if (b[p-3] && b[p-2] && !b[p-1] && b[p]) begin
        if (cnt == 0) first = i;
        if (cnt < 15) cnt++;
      end
    end
  endfunction

  task automatic do_word(input logic [7:0] d, input logic c, input int hold,
                         output int cnt_o, output int first_o);
    int ec, ef;
    model(d, c, prev_bits, ec, ef);
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    in_data = d;
    in_clr_det = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'($urandom);
    if (c) begin
      chk("clr_pulse", det_clr, 1);
      chk("clr_detx", det_x, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      chk("shift_detx", det_x, d[7-i]);
      chk("shift_noclr", det_clr, 0);
      chk("shift_ready", in_ready, 0);
      chk("shift_busy", busy, 1);
      @(negedge clk);
    end
    chk("tail_detx", det_x, 0);
    chk("tail_valid", res_valid, 0);
    @(negedge clk);
    chk("rep_valid", res_valid, 1);
    chk("rep_count", res_count, ec);
    chk("rep_first", res_first, ef);
    chk("rep_hit", res_hit, (ec != 0));
    chk("rep_noclr", det_clr, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = (h == 1);
      in_data = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_count", res_count, ec);
      chk("hold_first", res_first, ef);
      chk("hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    cnt_o = int'(res_count);
    first_o = int'(res_first);
    @(negedge clk);
    res_ready = 1'b0;
    chk("done_valid", res_valid, 0);
    chk("done_ready", in_ready, 1);
    chk("done_busy", busy, 0);
    prev_bits = d[2:0];
  endtask

  initial begin
    int c_o, f_o;
    int stale;
    logic [7:0] rd;
    logic rc;
    int rh;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", res_valid, 0);
    chk("rst_detx", det_x, 0);
    chk("rst_clr", det_clr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", res_count, 0);
    @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of shifting a word.
    @(negedge clk);
    in_data = 8'hDA;
    in_clr_det = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_detx", det_x, 0);
    chk("mid_valid", res_valid, 0);
    chk("mid_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    prev_bits = 3'b000;
    stale = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) stale++;
    end
    chk("mid_no_stale", stale, 0);

    do_word(8'b1101_1010, 1'b1, 0, c_o, f_o);
    chk("da_count", c_o, 2);
    chk("da_first", f_o, 3);

    do_word(8'b1101_1101, 1'b1, 5, c_o, f_o);
    chk("dd_count", c_o, 2);
    chk("dd_first", f_o, 3);

    do_word(8'hFF, 1'b0, 2, c_o, f_o);
    chk("ff_count", c_o, 0);
    chk("ff_first", f_o, 0);

    do_word(8'b0000_1101, 1'b0, 0, c_o, f_o);
    chk("x1_count", c_o, 1);
    chk("x1_first", f_o, 7);

    do_word(8'b1011_0000, 1'b0, 1, c_o, f_o);
    chk("x2_count", c_o, 0);
    chk("x2_first", f_o, 0);

    for (int n = 0; n < 30; n++) begin
      rd = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      rh = $urandom_range(0, 3);
      do_word(rd, rc, rh, c_o, f_o);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
